// File: rtl/board_ctrl_if.sv
// -----------------------------------------------------------------------------
// board_ctrl_if
//   Pin-side bundle of the board control block: raw buttons in, conditioned
//   buttons, system reset, long-press feedback and heartbeat out.
//
//   Parameters:
//     NUM_BTN      number of button channels
//   Signals:
//     btn_raw      raw asynchronous button pins          (board -> ctrl)
//     btn_level    debounced level, 1 = pressed          (ctrl -> board/core)
//     btn_press    one-cycle press pulse                 (ctrl -> core)
//     sys_rst_n    active-low system reset to the core   (ctrl -> core)
//     hold_active  long-press in progress (LED feedback) (ctrl -> board)
//     heartbeat    heartbeat LED square wave             (ctrl -> board)
//   Modports:
//     master       board side: drives btn_raw, observes everything else
//     slave        board_ctrl side: consumes btn_raw, drives the outputs
//
//   There is no valid/ready handshake on this bundle: btn_raw is a level
//   sampled every clock, and every output is a registered level that is
//   meaningful on every clock after the first reset edge.
// -----------------------------------------------------------------------------
interface board_ctrl_if #(
    parameter int NUM_BTN = 4
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic               sys_rst_n;
    logic               hold_active;
    logic               heartbeat;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  sys_rst_n,
        input  hold_active,
        input  heartbeat
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output sys_rst_n,
        output hold_active,
        output heartbeat
    );
endinterface

// File: rtl/board_ctrl.sv
// -----------------------------------------------------------------------------
// board_ctrl
//   Board-level control: per-button synchronise/normalise/debounce, a reset
//   FSM (POR -> RUN -> BTN_RST -> POR) that stretches the system reset after
//   power-up and after a long press of button RST_BTN, and a heartbeat LED.
//
//   Ports:
//     clk    in   pixel clock, all logic on the rising edge
//     reset  in   synchronous active-high reset (e.g. PLL not locked)
//     pins   board_ctrl_if.slave bundle (btn_raw in; btn_level, btn_press,
//            sys_rst_n, hold_active, heartbeat out)
//
//   Build option:
//     BOARD_CTRL_BTN_EDGE_EN  defined   -> btn_press pulses for one cycle on
//                                          the cycle btn_level first reads 1
//                             undefined -> btn_press tied to 0, no edge regs
//
//   All outputs are registered. The FSM state is held in 'state' for
//   observation by hierarchical checkers.
// -----------------------------------------------------------------------------
module board_ctrl #(
    parameter int                 NUM_BTN          = 4,
    parameter logic [NUM_BTN-1:0] ACTIVE_LOW_MASK  = NUM_BTN'(4'b0001),
    parameter int                 RST_BTN          = 0,
    parameter int                 DEBOUNCE_CYCLES  = 65536,
    parameter int                 POR_CYCLES       = 16,
    parameter int                 HOLD_CYCLES      = 25200000,
    parameter int                 HEARTBEAT_CYCLES = 25200000
) (
    input  logic        clk,
    input  logic        reset,
    board_ctrl_if.slave pins
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(POR_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int BW = $clog2(HEARTBEAT_CYCLES + 1);

    // Counters compare against N-1 before incrementing, so the N-th counted
    // edge is the one that acts ("reaches N").
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] POR_LAST  = PW'(POR_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] HB_LAST   = BW'(HEARTBEAT_CYCLES - 1);

    // ---------------- synchroniser + polarity normalisation ----------------
    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;
    logic [NUM_BTN-1:0] s_norm;

    // Reset value is the raw "not pressed" level, so s_norm reads 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= ACTIVE_LOW_MASK;
            sync2_q <= ACTIVE_LOW_MASK;
        end else begin
            sync1_q <= pins.btn_raw;
            sync2_q <= sync1_q;
        end
    end

    assign s_norm = sync2_q ^ ACTIVE_LOW_MASK;

    // ---------------- debounce ----------------
    logic [NUM_BTN-1:0] level_q;
    logic [NUM_BTN-1:0] level_nxt;
    logic [DW-1:0]      deb_cnt_q   [NUM_BTN];
    logic [DW-1:0]      deb_cnt_nxt [NUM_BTN];

    always_comb begin
        level_nxt = level_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            deb_cnt_nxt[i] = '0;
            if (s_norm[i] != level_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    level_nxt[i] = s_norm[i];
                end else begin
                    deb_cnt_nxt[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_nxt;
            for (int i = 0; i < NUM_BTN; i++) begin
                deb_cnt_q[i] <= deb_cnt_nxt[i];
            end
        end
    end

    assign pins.btn_level = level_q;

`ifdef BOARD_CTRL_BTN_EDGE_EN
    logic [NUM_BTN-1:0] press_q;

    // Registered alongside level_q, so the pulse lines up with the first
    // cycle the new level is visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            press_q <= '0;
        end else begin
            press_q <= level_nxt & ~level_q;
        end
    end

    assign pins.btn_press = press_q;
`else
    assign pins.btn_press = '0;
`endif

    // ---------------- reset FSM ----------------
    typedef enum logic [1:0] {
        ST_POR     = 2'd0,
        ST_RUN     = 2'd1,
        ST_BTN_RST = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] por_cnt;
    logic [HW-1:0] hold_cnt;
    logic          sys_rst_n_q;
    logic          hold_active_q;

    // RUN decides on the already-registered level, so a release landing on
    // the final hold edge is not seen and the reset still fires. BTN_RST
    // leaves on the same edge that the debounced release becomes visible.
    // hold_active_q is loaded from next-state values so it equals
    // (state == RUN) && btn_level[RST_BTN] in every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_POR;
            por_cnt       <= '0;
            hold_cnt      <= '0;
            sys_rst_n_q   <= 1'b0;
            hold_active_q <= 1'b0;
        end else begin
            case (state)
                ST_POR: begin
                    hold_active_q <= 1'b0;
                    if (por_cnt == POR_LAST) begin
                        state         <= ST_RUN;
                        por_cnt       <= '0;
                        sys_rst_n_q   <= 1'b1;
                        hold_active_q <= level_nxt[RST_BTN];
                    end else begin
                        por_cnt <= por_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (level_q[RST_BTN]) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state         <= ST_BTN_RST;
                            hold_cnt      <= '0;
                            sys_rst_n_q   <= 1'b0;
                            hold_active_q <= 1'b0;
                        end else begin
                            hold_cnt      <= hold_cnt + 1'b1;
                            hold_active_q <= level_nxt[RST_BTN];
                        end
                    end else begin
                        hold_cnt      <= '0;
                        hold_active_q <= level_nxt[RST_BTN];
                    end
                end
                ST_BTN_RST: begin
                    hold_active_q <= 1'b0;
                    if (!level_nxt[RST_BTN]) begin
                        state   <= ST_POR;
                        por_cnt <= '0;
                    end
                end
                default: begin
                    state         <= ST_POR;
                    por_cnt       <= '0;
                    hold_cnt      <= '0;
                    sys_rst_n_q   <= 1'b0;
                    hold_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign pins.sys_rst_n   = sys_rst_n_q;
    assign pins.hold_active = hold_active_q;

    // ---------------- heartbeat ----------------
    logic [BW-1:0] hb_cnt;
    logic          hb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hb_cnt <= '0;
            hb_q   <= 1'b0;
        end else if (hb_cnt == HB_LAST) begin
            hb_cnt <= '0;
            hb_q   <= ~hb_q;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
        end
    end

    assign pins.heartbeat = hb_q;

endmodule

// File: tb/tb_board_ctrl.sv
// -----------------------------------------------------------------------------
// tb_board_ctrl
//   Directed bench for board_ctrl with NUM_BTN=2, ACTIVE_LOW_MASK=2'b01,
//   DEBOUNCE=4, POR=8, HOLD=20, HEARTBEAT=10. A behavioural model updated on
//   every rising edge predicts all outputs; a compare process checks them on
//   every falling edge. Directed scenarios add hand-computed latencies.
// -----------------------------------------------------------------------------
module tb_board_ctrl;
    localparam int         NB    = 2;
    localparam logic [1:0] MASK  = 2'b01;
    localparam int         DEB   = 4;
    localparam int         POR   = 8;
    localparam int         HOLD  = 20;
    localparam int         HB    = 10;

    localparam int SIG_RST  = 0;
    localparam int SIG_HB   = 1;
    localparam int SIG_LVL0 = 2;
    localparam int SIG_LVL1 = 3;
    localparam int SIG_HOLD = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    board_ctrl_if #(.NUM_BTN(NB)) pins ();

    board_ctrl #(
        .NUM_BTN         (NB),
        .ACTIVE_LOW_MASK (MASK),
        .RST_BTN         (0),
        .DEBOUNCE_CYCLES (DEB),
        .POR_CYCLES      (POR),
        .HOLD_CYCLES     (HOLD),
        .HEARTBEAT_CYCLES(HB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .pins (pins)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases: 0 = power-on stretch, 1 = running, 2 = button-reset held.
    logic       m_valid = 1'b0;
    logic [1:0] m_level;
    logic [1:0] m_press;
    logic       m_rst_n;
    logic       m_hold_act;
    logic       m_hb;
    logic [1:0] raw_q[$];   // normalised samples still travelling the sync chain
    int         run [NB];   // consecutive edges the synced value disagreed
    int         phase;
    int         por_edges;
    int         held;
    int         edge_n;     // edges since reset release
    logic [1:0] m_s;
    logic [1:0] m_old;

    always @(posedge clk) begin
        if (reset) begin
            m_valid    = 1'b1;
            raw_q.delete();
            raw_q.push_back(2'b00);
            raw_q.push_back(2'b00);
            for (int i = 0; i < NB; i++) run[i] = 0;
            m_level    = 2'b00;
            m_press    = 2'b00;
            phase      = 0;
            por_edges  = 0;
            held       = 0;
            edge_n     = 0;
            m_rst_n    = 1'b0;
            m_hold_act = 1'b0;
            m_hb       = 1'b0;
        end else begin
            edge_n++;
            m_hb = ((edge_n / HB) % 2) == 1;

            m_s = raw_q.pop_front();
            raw_q.push_back(pins.btn_raw ^ MASK);

            m_old = m_level;
            for (int i = 0; i < NB; i++) begin
                if (m_s[i] != m_old[i]) begin
                    run[i]++;
                    if (run[i] == DEB) begin
                        m_level[i] = m_s[i];
                        run[i]     = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
`ifdef BOARD_CTRL_BTN_EDGE_EN
            m_press = m_level & ~m_old;
`else
            m_press = 2'b00;
`endif
            case (phase)
                0: begin
                    por_edges++;
                    if (por_edges == POR) phase = 1;
                end
                1: begin
                    if (m_old[0]) held++;
                    else held = 0;
                    if (held == HOLD) begin
                        phase = 2;
                        held  = 0;
                    end
                end
                default: begin
                    if (!m_level[0]) begin
                        phase     = 0;
                        por_edges = 0;
                    end
                end
            endcase
            m_rst_n    = (phase == 1);
            m_hold_act = (phase == 1) && m_level[0];
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_sys_rst_n",   int'(pins.sys_rst_n),   int'(m_rst_n));
            check("cyc_btn_level",   int'(pins.btn_level),   int'(m_level));
            check("cyc_btn_press",   int'(pins.btn_press),   int'(m_press));
            check("cyc_hold_active", int'(pins.hold_active), int'(m_hold_act));
            check("cyc_heartbeat",   int'(pins.heartbeat),   int'(m_hb));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    function automatic int get_sig(input int which);
        case (which)
            SIG_RST:  return int'(pins.sys_rst_n);
            SIG_HB:   return int'(pins.heartbeat);
            SIG_LVL0: return int'(pins.btn_level[0]);
            SIG_LVL1: return int'(pins.btn_level[1]);
            SIG_HOLD: return int'(pins.hold_active);
            default:  return 0;
        endcase
    endfunction

    // Edges until the signal reads val; -1 when the budget expires.
    task automatic count_until(input int which, input int val, input int limit,
                               output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (get_sig(which) == val) begin
                n = k;
                break;
            end
        end
    endtask

    // ---------------- directed stimulus ----------------
    int n;

    initial begin
        reset         = 1'b1;
        pins.btn_raw  = 2'b01;   // nothing pressed (btn 0 is active-low)
        @(negedge clk);
        tick(3);
        check("rst_sys_rst_n", int'(pins.sys_rst_n), 0);
        check("rst_btn_level", int'(pins.btn_level), 0);
        check("rst_heartbeat", int'(pins.heartbeat), 0);

        // Power-up
        reset = 1'b0;
        count_until(SIG_RST, 1, 30, n);
        check("por_release_edges", n, 8);
        count_until(SIG_HB, 1, 30, n);
        check("hb_first_toggle_extra", n, 2);
        count_until(SIG_HB, 0, 30, n);
        check("hb_second_toggle", n, 10);

        // Glitch on button 1
        pins.btn_raw[1] = 1'b1;
        tick(3);
        pins.btn_raw[1] = 1'b0;
        tick(10);
        check("glitch_level1", int'(pins.btn_level[1]), 0);

        // Clean step on button 1
        pins.btn_raw[1] = 1'b1;
        count_until(SIG_LVL1, 1, 20, n);
        check("step_latency", n, 6);
`ifdef BOARD_CTRL_BTN_EDGE_EN
        check("press_pulse_on", int'(pins.btn_press[1]), 1);
        tick(1);
        check("press_pulse_off", int'(pins.btn_press[1]), 0);
`else
        check("press_tied_low", int'(pins.btn_press), 0);
        tick(1);
        check("press_tied_low2", int'(pins.btn_press), 0);
`endif
        pins.btn_raw[1] = 1'b0;
        tick(10);
        check("step_release_level1", int'(pins.btn_level[1]), 0);

        // Long press on button 0 (active low)
        pins.btn_raw[0] = 1'b0;
        count_until(SIG_LVL0, 1, 20, n);
        check("lp_level_latency", n, 6);
        check("lp_hold_active", int'(pins.hold_active), 1);
        count_until(SIG_RST, 0, 40, n);
        check("lp_fire_edges", n, 20);
        check("lp_hold_active_off", int'(pins.hold_active), 0);
        tick(10);
        check("lp_held_in_reset", int'(pins.sys_rst_n), 0);
        pins.btn_raw[0] = 1'b1;
        count_until(SIG_RST, 1, 40, n);
        check("lp_release_edges", n, 14);

        // Two short presses (level high 15 cycles each)
        for (int r = 0; r < 2; r++) begin
            pins.btn_raw[0] = 1'b0;
            count_until(SIG_LVL0, 1, 20, n);
            check("sp_level_rise", n, 6);
            tick(9);
            pins.btn_raw[0] = 1'b1;
            count_until(SIG_LVL0, 0, 20, n);
            check("sp_level_fall", n, 6);
            tick(5);
            check("sp_no_reset", int'(pins.sys_rst_n), 1);
        end

        // Reset in the middle of a hold (hold count 12)
        pins.btn_raw[0] = 1'b0;
        count_until(SIG_LVL0, 1, 20, n);
        check("mh_level_rise", n, 6);
        tick(12);
        check("mh_still_running", int'(pins.sys_rst_n), 1);
        reset = 1'b1;
        tick(1);
        check("mh_rst_sys_rst_n",   int'(pins.sys_rst_n),   0);
        check("mh_rst_btn_level",   int'(pins.btn_level),   0);
        check("mh_rst_btn_press",   int'(pins.btn_press),   0);
        check("mh_rst_hold_active", int'(pins.hold_active), 0);
        check("mh_rst_heartbeat",   int'(pins.heartbeat),   0);
        tick(1);
        reset = 1'b0;
        count_until(SIG_RST, 1, 30, n);
        check("mh_por_edges", n, 8);
        count_until(SIG_RST, 0, 40, n);
        check("mh_hold_restart", n, 20);
        pins.btn_raw[0] = 1'b1;
        count_until(SIG_RST, 1, 40, n);
        check("mh_release_edges", n, 14);

        tick(5);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
